// File: rtl/mem_proxy_arb_pkg.sv
// Shared types for the memory proxy arbiter family.
//   state_e : access sequencer states (IDLE -> MEM -> CAP -> IDLE)
//   port_e  : requester identity carried with each access
//   PROT_BASE_DEFAULT : default first address of the protected window
package mem_proxy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    CAP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_EXT  = 1'b0,
    PORT_PRIV = 1'b1
  } port_e;

  localparam logic [7:0] PROT_BASE_DEFAULT = 8'hC0;

endpackage

// File: rtl/mem_proxy_arbiter_if.sv
// Bus bundles for the memory proxy arbiter.
//   mem_proxy_req_if : one requester port (request handshake + response slot).
//     master = requester fabric, slave = arbiter.
//   mem_proxy_mem_if : single-port memory bus (cs/wr/addr/wdata out, rdata in,
//     rdata valid the cycle after cs). master = arbiter, slave = memory array.
interface mem_proxy_req_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface mem_proxy_mem_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cs;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output cs, wr, addr, wdata, input rdata);
  modport slave  (input cs, wr, addr, wdata, output rdata);
endinterface

// File: rtl/mem_proxy_access_check.sv
// Combinational access policy: an external access into [PROT_BASE, top of
// address space] is denied; privileged accesses always pass.
//   port   in  requester identity
//   addr   in  access address
//   denied out 1 = access must not reach memory
module mem_proxy_access_check
  import mem_proxy_arb_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PROT_BASE = ADDR_WIDTH'(PROT_BASE_DEFAULT)
) (
  input  port_e                 port,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  denied
);

  assign denied = (port == PORT_EXT) && (addr >= PROT_BASE);

endmodule

// File: rtl/mem_proxy_arbiter.sv
// Sole master of a shared single-port memory, serving an external and a
// privileged requester. One access at a time: IDLE (grant) -> MEM (strobe)
// -> CAP (capture into the owner's response slot). External accesses into
// the protected window are denied without touching memory and counted.
//   clk, reset      clock, async active-high reset
//   ext, priv       requester ports (req handshake + response slot)
//   mem             memory bus
//   viol_count      saturating count of denied external requests
//   viol_irq        sticky denial flag
module mem_proxy_arbiter
  import mem_proxy_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] PROT_BASE    = ADDR_WIDTH'(PROT_BASE_DEFAULT),
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_proxy_req_if.slave       ext,
  mem_proxy_req_if.slave       priv,
  mem_proxy_mem_if.master      mem,
  output logic [7:0]           viol_count,
  output logic                 viol_irq
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e                state_q, state_d;
  port_e                 port_q, port_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  denied_q, denied_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  ext_vld_q, ext_vld_d;
  logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;
  logic                  ext_err_q, ext_err_d;
  logic                  priv_vld_q, priv_vld_d;
  logic [DATA_WIDTH-1:0] priv_rdata_q, priv_rdata_d;
  logic [7:0]            viol_count_q, viol_count_d;
  logic                  viol_irq_q, viol_irq_d;

  logic                  ext_elig, priv_elig, at_limit;
  logic                  grant_ext, grant_priv;
  port_e                 sel_port;
  logic                  chk_denied;
  logic [DATA_WIDTH-1:0] cap_rdata;

  // A slot being drained on this edge counts as empty, so a requester that
  // consumes its response every cycle can be granted again immediately.
  assign ext_elig  = ext.req_valid  && (!ext_vld_q  || ext.rsp_ready);
  assign priv_elig = priv.req_valid && (!priv_vld_q || priv.rsp_ready);
  assign at_limit  = (starve_q == SW'(STARVE_LIMIT));

  assign grant_priv = (state_q == IDLE) && priv_elig && !(ext_elig && at_limit);
  assign grant_ext  = (state_q == IDLE) && ext_elig && !grant_priv;
  assign sel_port   = grant_priv ? PORT_PRIV : PORT_EXT;

  mem_proxy_access_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROT_BASE  (PROT_BASE)
  ) u_check (
    .port   (sel_port),
    .addr   (grant_priv ? priv.req_addr : ext.req_addr),
    .denied (chk_denied)
  );

  assign cap_rdata = (!denied_q && !wr_q) ? mem.rdata : '0;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    denied_d     = denied_q;
    starve_d     = starve_q;
    ext_vld_d    = ext_vld_q;
    ext_rdata_d  = ext_rdata_q;
    ext_err_d    = ext_err_q;
    priv_vld_d   = priv_vld_q;
    priv_rdata_d = priv_rdata_q;
    viol_count_d = viol_count_q;
    viol_irq_d   = viol_irq_q;

    if (ext_vld_q && ext.rsp_ready)   ext_vld_d  = 1'b0;
    if (priv_vld_q && priv.rsp_ready) priv_vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ext || grant_priv) begin
          state_d  = MEM;
          port_d   = sel_port;
          wr_d     = grant_priv ? priv.req_wr    : ext.req_wr;
          addr_d   = grant_priv ? priv.req_addr  : ext.req_addr;
          wdata_d  = grant_priv ? priv.req_wdata : ext.req_wdata;
          denied_d = chk_denied;
          // Only privileged wins that actually made external wait count.
          if (grant_ext)
            starve_d = '0;
          else if (ext_elig && !at_limit)
            starve_d = starve_q + 1'b1;
        end
      end
      MEM: state_d = CAP;
      CAP: begin
        state_d = IDLE;
        if (port_q == PORT_EXT) begin
          ext_vld_d   = 1'b1;
          ext_rdata_d = cap_rdata;
          ext_err_d   = denied_q;
          if (denied_q) begin
            viol_irq_d = 1'b1;
            if (viol_count_q != 8'hFF) viol_count_d = viol_count_q + 8'd1;
          end
        end else begin
          priv_vld_d   = 1'b1;
          priv_rdata_d = cap_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      port_q       <= PORT_EXT;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      denied_q     <= 1'b0;
      starve_q     <= '0;
      ext_vld_q    <= 1'b0;
      ext_rdata_q  <= '0;
      ext_err_q    <= 1'b0;
      priv_vld_q   <= 1'b0;
      priv_rdata_q <= '0;
      viol_count_q <= '0;
      viol_irq_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      denied_q     <= denied_d;
      starve_q     <= starve_d;
      ext_vld_q    <= ext_vld_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_err_q    <= ext_err_d;
      priv_vld_q   <= priv_vld_d;
      priv_rdata_q <= priv_rdata_d;
      viol_count_q <= viol_count_d;
      viol_irq_q   <= viol_irq_d;
    end
  end

  assign ext.req_ready  = grant_ext;
  assign ext.rsp_valid  = ext_vld_q;
  assign ext.rsp_rdata  = ext_rdata_q;
  assign ext.rsp_err    = ext_err_q;
  assign priv.req_ready = grant_priv;
  assign priv.rsp_valid = priv_vld_q;
  assign priv.rsp_rdata = priv_rdata_q;
  assign priv.rsp_err   = 1'b0;

  // Bus is quiet outside an allowed MEM cycle; a denied access never strobes.
  assign mem.cs    = (state_q == MEM) && !denied_q;
  assign mem.wr    = mem.cs && wr_q;
  assign mem.addr  = mem.cs ? addr_q : '0;
  assign mem.wdata = (mem.cs && wr_q) ? wdata_q : '0;

  assign viol_count = viol_count_q;
  assign viol_irq   = viol_irq_q;

endmodule
